// File: rtl/paddle_ai_ctrl.sv
// Computer-player paddle controller: react delay, move prescaler, dead zone.
// Optional AI_RETURN_CENTRE_EN steers the paddle to screen centre while idle.
module paddle_ai_ctrl #(
  parameter int oHeight     = 150,
  parameter int sHeight     = 600,
  parameter int DEADZONE    = 8,
  parameter int MOVE_DIV    = 4,
  parameter int REACT_DELAY = 16
) (
  input  logic        PixelClock,
  input  logic        Reset,
  input  logic        enable,
  input  logic        ballDirX,
  input  logic [10:0] ballPosY,
  input  logic [10:0] padPosY,
  output logic [1:0]  butCont,
  output logic [1:0]  aiState
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REACT = 2'b01,
    TRACK = 2'b10,
    BAD   = 2'b11
  } state_t;

  localparam int RW = (REACT_DELAY > 1) ? $clog2(REACT_DELAY) : 1;
  localparam int DW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic [RW-1:0] REACT_LD = RW'(REACT_DELAY - 1);
  localparam logic [DW-1:0] DIV_MAX  = DW'(MOVE_DIV - 1);
  localparam logic signed [12:0] DZ  = 13'(DEADZONE);
  localparam logic [11:0] HALF_PAD   = 12'(oHeight / 2);

  state_t        state_q, state_d;
  logic [RW-1:0] react_q, react_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    but_q, but_d;

  logic [11:0]        centre;
  logic signed [12:0] err_ball;
  logic               tick;

  // One extra sign bit keeps the error exact for any 11-bit inputs.
  assign centre   = {1'b0, padPosY} + HALF_PAD;
  assign err_ball = $signed({2'b00, ballPosY}) - $signed({1'b0, centre});
  assign tick     = (div_q == DIV_MAX);

  function automatic logic [1:0] steer(input logic signed [12:0] e);
    if (e < -DZ)     steer = 2'b10;
    else if (e > DZ) steer = 2'b01;
    else             steer = 2'b00;
  endfunction

  function automatic logic [DW-1:0] div_next(input logic [DW-1:0] d);
    if (d == DIV_MAX) div_next = '0;
    else              div_next = d + 1'b1;
  endfunction

`ifdef AI_RETURN_CENTRE_EN
  localparam logic [11:0] SCR_MID = 12'(sHeight / 2);
  logic signed [12:0] err_mid;
  assign err_mid = $signed({1'b0, SCR_MID}) - $signed({1'b0, centre});
`endif

  always_comb begin
    state_d = state_q;
    react_d = react_q;
    div_d   = div_q;
    but_d   = 2'b00;
    case (state_q)
      IDLE: begin
`ifdef AI_RETURN_CENTRE_EN
        if (enable) begin
          div_d = div_next(div_q);
          if (tick) but_d = steer(err_mid);
        end else begin
          div_d = '0;
        end
`else
        div_d = '0;
`endif
        // Leaving IDLE wins over any centring pulse.
        if (enable && ballDirX) begin
          state_d = REACT;
          react_d = REACT_LD;
          div_d   = '0;
          but_d   = 2'b00;
        end
      end
      REACT: begin
        if (!enable || !ballDirX) begin
          state_d = IDLE;
        end else if (react_q == '0) begin
          state_d = TRACK;
          div_d   = '0;
        end else begin
          react_d = react_q - 1'b1;
        end
      end
      TRACK: begin
        if (!enable || !ballDirX) begin
          state_d = IDLE;
          div_d   = '0;
        end else begin
          div_d = div_next(div_q);
          if (tick) but_d = steer(err_ball);
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
      end
    endcase
  end

  always_ff @(posedge PixelClock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      react_q <= '0;
      div_q   <= '0;
      but_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      react_q <= react_d;
      div_q   <= div_d;
      but_q   <= but_d;
    end
  end

  assign butCont = but_q;
  assign aiState = state_q;

endmodule

// File: tb/tb_paddle_ai_ctrl.sv
// Directed bench for paddle_ai_ctrl with a queue scoreboard.
// Expected {aiState,butCont} pairs are pushed when driven, popped after the edge.
module tb_paddle_ai_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        ballDirX;
  logic [10:0] ballPosY;
  logic [10:0] padPosY;
  logic [1:0]  butCont;
  logic [1:0]  aiState;

  int n_vec  = 0;
  int n_fail = 0;
  logic [3:0] sb[$];

  paddle_ai_ctrl dut (
    .PixelClock(clk),
    .Reset(rst),
    .enable(enable),
    .ballDirX(ballDirX),
    .ballPosY(ballPosY),
    .padPosY(padPosY),
    .butCont(butCont),
    .aiState(aiState)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {aiState, butCont};
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] exp);
    sb.push_back(exp);
    @(posedge clk);
    #1;
    check(tag, sb.pop_front());
  endtask

  task automatic go_idle(input string tag);
    @(negedge clk);
    enable   = 1'b0;
    ballDirX = 1'b0;
    step(tag, 4'b0000);
    step(tag, 4'b0000);
  endtask

  // Trigger on edge 0; ballDirX drops before edge 'drop' (negative = never).
  task automatic track(input string tag, input logic [10:0] pad,
                       input logic [10:0] ball, input logic [1:0] dir,
                       input int n, input int drop);
    logic [1:0] st, bt;
    @(negedge clk);
    padPosY  = pad;
    ballPosY = ball;
    enable   = 1'b1;
    ballDirX = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      if (k == drop) ballDirX = 1'b0;
      if (drop >= 0 && k >= drop) begin
        st = 2'b00;
        bt = 2'b00;
      end else begin
        st = (k < 16) ? 2'b01 : 2'b10;
        bt = (k >= 20 && (k - 20) % 4 == 0) ? dir : 2'b00;
      end
      step(tag, {st, bt});
    end
  endtask

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    ballDirX = 1'b0;
    ballPosY = 11'd0;
    padPosY  = 11'd0;
    #12;
    check("reset", 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    step("idle", 4'b0000);

    track("down", 11'd225, 11'd400, 2'b01, 30, -1);
    go_idle("down_exit");
    track("up", 11'd225, 11'd100, 2'b10, 30, -1);
    go_idle("up_exit");
    track("dz_p8", 11'd225, 11'd308, 2'b00, 30, -1);
    go_idle("dz_p8_exit");
    track("dz_p9", 11'd225, 11'd309, 2'b01, 30, -1);
    go_idle("dz_p9_exit");
    track("dz_m8", 11'd225, 11'd292, 2'b00, 30, -1);
    go_idle("dz_m8_exit");
    track("dz_m9", 11'd225, 11'd291, 2'b10, 30, -1);
    go_idle("dz_m9_exit");
    track("abort_react", 11'd225, 11'd400, 2'b01, 24, 10);
    go_idle("abort_react_exit");
    track("abort_tick", 11'd225, 11'd400, 2'b01, 32, 28);
    go_idle("abort_tick_exit");

    // Reset asserted mid-cycle while a down pulse is showing.
    track("pre_reset", 11'd225, 11'd400, 2'b01, 21, -1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 4'b0000);
    @(negedge clk);
    rst      = 1'b0;
    enable   = 1'b0;
    ballDirX = 1'b0;
    step("post_reset", 4'b0000);

    // Idle with enable: centring pulses only when the option is built in.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    @(negedge clk);
    padPosY  = 11'd100;
    ballPosY = 11'd500;
    enable   = 1'b1;
    ballDirX = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
`ifdef AI_RETURN_CENTRE_EN
      step("centre", (k % 4 == 0) ? 4'b0001 : 4'b0000);
`else
      step("centre", 4'b0000);
`endif
    end

    if (sb.size() != 0) begin
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
